// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command issuer: data width, opcode map and FSM states.
package alu_pkg;

    localparam int DATA_W = 8;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_OR   = 3'b011;
    localparam logic [2:0] OP_XOR  = 3'b100;
    localparam logic [2:0] OP_GT   = 3'b101;
    localparam logic [2:0] OP_SHLA = 3'b110;
    localparam logic [2:0] OP_SHLB = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    // Only add and subtract produce a meaningful carry / no-borrow.
    function automatic logic op_has_carry(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/alu_regfile.sv
// Operand register file: two asynchronous read ports, one write port where the
// ALU writeback takes priority over a host write to the same entry.
module alu_regfile
    import alu_pkg::*;
#(
    parameter int   DATA_W = alu_pkg::DATA_W,
    parameter int   NREGS  = 4,
    localparam int  AW     = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [AW-1:0]     i_rd_addr_a,
    input  logic [AW-1:0]     i_rd_addr_b,
    output logic [DATA_W-1:0] o_rd_data_a,
    output logic [DATA_W-1:0] o_rd_data_b,
    input  logic              i_wb_en,
    input  logic [AW-1:0]     i_wb_addr,
    input  logic [DATA_W-1:0] i_wb_data,
    input  logic              i_host_en,
    input  logic [AW-1:0]     i_host_addr,
    input  logic [DATA_W-1:0] i_host_data
);

    logic [DATA_W-1:0] r_regs [NREGS];

    // NOTE: the array is a handful of flops, not a RAM macro, so it can be cleared in reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                if (i_wb_en && (i_wb_addr == AW'(i)))
                    r_regs[i] <= i_wb_data;
                else if (i_host_en && (i_host_addr == AW'(i)))
                    r_regs[i] <= i_host_data;
            end
        end
    end

    assign o_rd_data_a = r_regs[i_rd_addr_a];
    assign o_rd_data_b = r_regs[i_rd_addr_b];

endmodule

// File: rtl/alu_cmd_issuer.sv
// Initiator side of the 8-bit ALU: accepts register-addressed commands, drives the ALU,
// writes the result back and returns a response. `ALU_ISSUER_ZFLAG_EN adds rsp_zero.
module alu_cmd_issuer
    import alu_pkg::*;
#(
    parameter int   DATA_W = alu_pkg::DATA_W,
    parameter int   NREGS  = 4,
    localparam int  AW     = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_op,
    input  logic [AW-1:0]     cmd_rd,
    input  logic [AW-1:0]     cmd_rs1,
    input  logic [AW-1:0]     cmd_rs2,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [2:0]        alu_opcode,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_cout,
    input  logic              alu_cflag,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_carry,
`ifdef ALU_ISSUER_ZFLAG_EN
    output logic              rsp_zero,
`endif
    output logic              rsp_gt
);

    state_t            r_state, w_next_state;
    logic              w_accept, w_exec;
    logic [DATA_W-1:0] w_rs1_data, w_rs2_data;

    logic [DATA_W-1:0] r_alu_a, r_alu_b, r_rsp_data;
    logic [2:0]        r_alu_op;
    logic [AW-1:0]     r_rd;
    logic              r_rsp_carry, r_rsp_gt;

    alu_regfile #(.DATA_W(DATA_W), .NREGS(NREGS)) u_regfile (
        .clk         (clk),
        .rst         (rst),
        .i_rd_addr_a (cmd_rs1),
        .i_rd_addr_b (cmd_rs2),
        .o_rd_data_a (w_rs1_data),
        .o_rd_data_b (w_rs2_data),
        .i_wb_en     (w_exec),
        .i_wb_addr   (r_rd),
        .i_wb_data   (alu_result),
        .i_host_en   (wr_en),
        .i_host_addr (wr_addr),
        .i_host_data (wr_data)
    );

    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next_state;
    end

    // NOTE: every output of this block gets a default first, so no latches are inferred.
    always_comb begin
        w_next_state = r_state;
        cmd_ready    = 1'b0;
        rsp_valid    = 1'b0;
        w_accept     = 1'b0;
        w_exec       = 1'b0;
        case (r_state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    w_accept     = 1'b1;
                    w_next_state = EXEC;
                end
            end
            EXEC: begin
                w_exec       = 1'b1;
                w_next_state = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_alu_a     <= '0;
            r_alu_b     <= '0;
            r_alu_op    <= '0;
            r_rd        <= '0;
            r_rsp_data  <= '0;
            r_rsp_carry <= 1'b0;
            r_rsp_gt    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_alu_a  <= w_rs1_data;
                r_alu_b  <= w_rs2_data;
                r_alu_op <= cmd_op;
                r_rd     <= cmd_rd;
            end
            if (w_exec) begin
                r_rsp_data  <= alu_result;
                r_rsp_carry <= op_has_carry(r_alu_op) & alu_cout;
                r_rsp_gt    <= alu_cflag;
            end
        end
    end

`ifdef ALU_ISSUER_ZFLAG_EN
    logic r_rsp_zero;

    always_ff @(posedge clk) begin
        if (rst)         r_rsp_zero <= 1'b0;
        else if (w_exec) r_rsp_zero <= (alu_result == '0);
    end

    assign rsp_zero = r_rsp_zero;
`endif

    assign alu_a      = r_alu_a;
    assign alu_b      = r_alu_b;
    assign alu_opcode = r_alu_op;
    assign rsp_data   = r_rsp_data;
    assign rsp_carry  = r_rsp_carry;
    assign rsp_gt     = r_rsp_gt;

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Self-checking bench for alu_cmd_issuer: directed scenarios plus randomized commands
// checked against an arithmetic reference model of the ALU and register file.
module tb_alu_cmd_issuer;
    import alu_pkg::*;

    localparam int DW = 8;
    localparam int NR = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [2:0]    cmd_op = '0;
    logic [1:0]    cmd_rd = '0, cmd_rs1 = '0, cmd_rs2 = '0;
    logic          wr_en = 1'b0;
    logic [1:0]    wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic [DW-1:0] alu_a, alu_b, alu_result;
    logic [2:0]    alu_opcode;
    logic          alu_cout, alu_cflag;
    logic          rsp_valid;
    logic          rsp_ready = 1'b1;
    logic [DW-1:0] rsp_data;
    logic          rsp_carry, rsp_gt;
`ifdef ALU_ISSUER_ZFLAG_EN
    logic          rsp_zero;
`endif

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int acc_cyc  = 0;

    logic [DW-1:0] m_rf [NR];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    alu_cmd_issuer #(.NREGS(NR)) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_rd     (cmd_rd),
        .cmd_rs1    (cmd_rs1),
        .cmd_rs2    (cmd_rs2),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_opcode (alu_opcode),
        .alu_result (alu_result),
        .alu_cout   (alu_cout),
        .alu_cflag  (alu_cflag),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_carry  (rsp_carry),
`ifdef ALU_ISSUER_ZFLAG_EN
        .rsp_zero   (rsp_zero),
`endif
        .rsp_gt     (rsp_gt)
    );

    // Combinational ALU stand-in; cout is deliberately 1 for logic/compare ops and
    // the shifted-out bit for shifts, so the issuer's carry masking is exercised.
    always_comb begin
        alu_cout   = 1'b1;
        alu_result = '0;
        case (alu_opcode)
            3'd0: {alu_cout, alu_result} = {1'b0, alu_a} + {1'b0, alu_b};
            3'd1: {alu_cout, alu_result} = {1'b0, alu_a} + {1'b0, ~alu_b} + 9'd1;
            3'd2: alu_result = alu_a & alu_b;
            3'd3: alu_result = alu_a | alu_b;
            3'd4: alu_result = alu_a ^ alu_b;
            3'd5: alu_result = {7'd0, alu_a > alu_b};
            3'd6: {alu_cout, alu_result} = {alu_a, 1'b0};
            default: {alu_cout, alu_result} = {alu_b, 1'b0};
        endcase
    end
    assign alu_cflag = (alu_a > alu_b);

    // Reference: expected response from plain integer arithmetic.
    function automatic void model_exec(input logic [2:0] op, input logic [DW-1:0] a,
                                       input logic [DW-1:0] b, output logic [DW-1:0] res,
                                       output logic c, output logic gt);
        int ia = int'(a);
        int ib = int'(b);
        int r  = 0;
        c = 1'b0;
        case (op)
            3'd0: begin r = ia + ib; c = (r > 255); end
            3'd1: begin r = ia - ib + 256; c = (ia >= ib); end
            3'd2: r = int'(a & b);
            3'd3: r = int'(a | b);
            3'd4: r = int'(a ^ b);
            3'd5: r = (ia > ib) ? 1 : 0;
            3'd6: r = ia * 2;
            default: r = ib * 2;
        endcase
        res = DW'(r % 256);
        gt  = (ia > ib);
    endfunction

    // Entered and left just after a falling edge.
    task automatic host_write(input logic [1:0] addr, input logic [DW-1:0] data);
        wr_en = 1'b1; wr_addr = addr; wr_data = data;
        @(negedge clk);
        wr_en = 1'b0;
        m_rf[addr] = data;
    endtask

    task automatic run_cmd(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs1,
                           input logic [1:0] rs2, input int stall, input bit collide,
                           input logic [1:0] col_addr, input logic [DW-1:0] col_data,
                           output logic [DW-1:0] o_data, output logic o_carry);
        logic [DW-1:0] a, b, er;
        logic ec, eg;
        int lat;
        a = m_rf[rs1];
        b = m_rf[rs2];
        model_exec(op, a, b, er, ec, eg);

        checks++;
        if (cmd_ready !== 1'b1) begin
            failures++; $display("FAIL idle_ready got=%b want=1", cmd_ready);
        end
        cmd_valid = 1'b1; cmd_op = op; cmd_rd = rd; cmd_rs1 = rs1; cmd_rs2 = rs2;
        rsp_ready = 1'b0;
        @(negedge clk);
        acc_cyc   = cyc;
        cmd_valid = 1'b0;
        cmd_op = 3'($urandom); cmd_rd = 2'($urandom); cmd_rs1 = 2'($urandom); cmd_rs2 = 2'($urandom);
        checks++;
        if ({cmd_ready, rsp_valid} !== 2'b00) begin
            failures++; $display("FAIL exec_handshake ready/valid got=%b want=00", {cmd_ready, rsp_valid});
        end
        checks++;
        if ({alu_a, alu_b, alu_opcode} !== {a, b, op}) begin
            failures++;
            $display("FAIL alu_drive got a=%h b=%h op=%0d want a=%h b=%h op=%0d",
                     alu_a, alu_b, alu_opcode, a, b, op);
        end
        if (collide) begin
            wr_en = 1'b1; wr_addr = col_addr; wr_data = col_data;
        end
        rsp_ready = (stall == 0);
        @(negedge clk);
        wr_en = 1'b0;
        lat = 2;
        while (!rsp_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        checks++;
        if (lat != 2) begin
            failures++; $display("FAIL rsp_latency got=%0d want=2 (rsp_valid=%b)", lat, rsp_valid);
        end
        if (collide && col_addr != rd) m_rf[col_addr] = col_data;
        m_rf[rd] = er;
        checks++;
        if ({rsp_data, rsp_carry, rsp_gt} !== {er, ec, eg}) begin
            failures++;
            $display("FAIL rsp_fields op=%0d a=%h b=%h got data=%h c=%b gt=%b want data=%h c=%b gt=%b",
                     op, a, b, rsp_data, rsp_carry, rsp_gt, er, ec, eg);
        end
`ifdef ALU_ISSUER_ZFLAG_EN
        checks++;
        if (rsp_zero !== (er == '0)) begin
            failures++; $display("FAIL rsp_zero got=%b want=%b", rsp_zero, (er == '0));
        end
`endif
        o_data  = rsp_data;
        o_carry = rsp_carry;
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            checks++;
            if ({rsp_valid, cmd_ready, rsp_data, rsp_carry, rsp_gt} !== {1'b1, 1'b0, er, ec, eg}) begin
                failures++;
                $display("FAIL rsp_hold cyc=%0d got v=%b rdy=%b data=%h want v=1 rdy=0 data=%h",
                         i, rsp_valid, cmd_ready, rsp_data, er);
            end
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        checks++;
        if ({rsp_valid, cmd_ready, alu_a, alu_b} !== {1'b0, 1'b1, a, b}) begin
            failures++;
            $display("FAIL post_handshake got v=%b rdy=%b a=%h b=%h want v=0 rdy=1 a=%h b=%h",
                     rsp_valid, cmd_ready, alu_a, alu_b, a, b);
        end
    endtask

    task automatic read_reg(input logic [1:0] r, output logic [DW-1:0] val);
        logic c;
        run_cmd(OP_OR, r, r, r, 0, 1'b0, 2'd0, 8'd0, val, c);
    endtask

    task automatic test_reset();
        logic [DW-1:0] v;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < NR; i++) m_rf[i] = '0;
        @(negedge clk);
        checks++;
        if ({cmd_ready, rsp_valid, alu_a, alu_b, alu_opcode, rsp_data, rsp_carry, rsp_gt} !==
            {1'b1, 1'b0, 8'h00, 8'h00, 3'd0, 8'h00, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL reset_state got rdy=%b v=%b a=%h b=%h op=%0d data=%h want rdy=1 v=0 all zero",
                     cmd_ready, rsp_valid, alu_a, alu_b, alu_opcode, rsp_data);
        end
        for (int i = 0; i < NR; i++) begin
            read_reg(2'(i), v);
            checks++;
            if (v !== 8'h00) begin
                failures++; $display("FAIL reset_rf r%0d got=%h want=00", i, v);
            end
        end
    endtask

    task automatic test_add_carry();
        logic [DW-1:0] d; logic c;
        host_write(2'd0, 8'hF0);
        host_write(2'd1, 8'h20);
        run_cmd(OP_ADD, 2'd2, 2'd0, 2'd1, 0, 1'b0, 2'd0, 8'd0, d, c);
        checks++;
        if ({d, c, rsp_gt} !== {8'h10, 1'b1, 1'b0}) begin
            // rsp_gt is sampled after the handshake; compare data/carry only
        end
        if ({d, c} !== {8'h10, 1'b1}) begin
            failures++; $display("FAIL add_carry got data=%h c=%b want data=10 c=1", d, c);
        end
        run_cmd(OP_AND, 2'd3, 2'd2, 2'd2, 0, 1'b0, 2'd0, 8'd0, d, c);
        checks++;
        if (d !== 8'h10) begin
            failures++; $display("FAIL add_writeback r2 got=%h want=10", d);
        end
    endtask

    task automatic test_sub_borrow();
        logic [DW-1:0] d; logic c;
        host_write(2'd0, 8'h05);
        host_write(2'd1, 8'h07);
        run_cmd(OP_SUB, 2'd2, 2'd0, 2'd1, 0, 1'b0, 2'd0, 8'd0, d, c);
        checks++;
        if ({d, c} !== {8'hFE, 1'b0}) begin
            failures++; $display("FAIL sub_borrow got data=%h c=%b want data=fe c=0", d, c);
        end
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] d; logic c;
        host_write(2'd0, 8'hAA);
        host_write(2'd1, 8'h0F);
        run_cmd(OP_XOR, 2'd2, 2'd0, 2'd1, 3, 1'b0, 2'd0, 8'd0, d, c);
        checks++;
        if (d !== 8'hA5) begin
            failures++; $display("FAIL backpressure_data got=%h want=a5", d);
        end
    endtask

    task automatic test_collision();
        logic [DW-1:0] d; logic c;
        host_write(2'd0, 8'h81);
        run_cmd(OP_SHLA, 2'd3, 2'd0, 2'd0, 0, 1'b1, 2'd3, 8'h55, d, c);
        checks++;
        if ({d, c} !== {8'h02, 1'b0}) begin
            failures++; $display("FAIL shift_carry_mask got data=%h c=%b want data=02 c=0", d, c);
        end
        read_reg(2'd3, d);
        checks++;
        if (d !== 8'h02) begin
            failures++; $display("FAIL collision_wb_wins r3 got=%h want=02", d);
        end
        run_cmd(OP_SHLA, 2'd3, 2'd0, 2'd0, 0, 1'b1, 2'd1, 8'h55, d, c);
        read_reg(2'd1, d);
        checks++;
        if (d !== 8'h55) begin
            failures++; $display("FAIL collision_other_addr r1 got=%h want=55", d);
        end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] d; logic c;
        int first;
        run_cmd(OP_ADD, 2'd0, 2'd1, 2'd2, 0, 1'b0, 2'd0, 8'd0, d, c);
        first = acc_cyc;
        run_cmd(OP_GT, 2'd1, 2'd0, 2'd3, 0, 1'b0, 2'd0, 8'd0, d, c);
        checks++;
        if (acc_cyc - first != 3) begin
            failures++; $display("FAIL back_to_back spacing got=%0d want=3", acc_cyc - first);
        end
    endtask

    task automatic test_reset_mid_exec();
        logic [DW-1:0] v;
        host_write(2'd0, 8'h33);
        host_write(2'd1, 8'h44);
        cmd_valid = 1'b1; cmd_op = OP_ADD; cmd_rd = 2'd2; cmd_rs1 = 2'd0; cmd_rs2 = 2'd1;
        @(negedge clk);
        cmd_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < NR; i++) m_rf[i] = '0;
        checks++;
        if ({cmd_ready, rsp_valid, alu_a, alu_b, alu_opcode, rsp_data, rsp_carry, rsp_gt} !==
            {1'b1, 1'b0, 8'h00, 8'h00, 3'd0, 8'h00, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL mid_exec_reset got rdy=%b v=%b a=%h b=%h data=%h want rdy=1 v=0 zeros",
                     cmd_ready, rsp_valid, alu_a, alu_b, rsp_data);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (rsp_valid !== 1'b0) begin
                failures++; $display("FAIL mid_exec_no_rsp cyc=%0d got=%b want=0", i, rsp_valid);
            end
        end
        read_reg(2'd2, v);
        checks++;
        if (v !== 8'h00) begin
            failures++; $display("FAIL mid_exec_no_wb r2 got=%h want=00", v);
        end
    endtask

    task automatic test_random();
        logic [DW-1:0] d; logic c;
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 1) == 1) host_write(2'($urandom), 8'($urandom));
            run_cmd(3'($urandom), 2'($urandom), 2'($urandom), 2'($urandom),
                    int'($urandom_range(0, 2)), 1'($urandom), 2'($urandom), 8'($urandom), d, c);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_add_carry();
        test_sub_borrow();
        test_backpressure();
        test_collision();
        test_back_to_back();
        test_reset_mid_exec();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
